counter_scheduler: RTL and testbench

//   Shares a single up-counter timer between NUM_REQ requesters using round-robin arbitration.

---
 rtl/counter_scheduler.sv | 143 ++++++++++++++
 tb/tb_counter_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// Round-robin arbiter that lends one shared up-counter to NUM_REQ requesters.
// The winner's delay is latched at grant time, and a one-cycle done pulse is issued when the delay expires.
module counter_scheduler #(
   parameter int NUM_REQ           = 4,
   parameter int COUNTER_MSB       = 6,
   parameter int COUNTER_THRESHOLD = 127
) (
   input  logic                               i_CLK,
   input  logic                               i_RST_N,
   input  logic [NUM_REQ-1:0]                 i_REQ,
   input  logic [NUM_REQ*(COUNTER_MSB+1)-1:0] i_DELAY,
   output logic [NUM_REQ-1:0]                 o_GNT,
   output logic [NUM_REQ-1:0]                 o_DONE,
   output logic                               o_BUSY,
   output logic [COUNTER_MSB:0]               o_COUNT,
   output logic                               o_OVER_RUN
);

   localparam int W  = COUNTER_MSB + 1;
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [W-1:0] THRESH = W'(COUNTER_THRESHOLD);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [PW-1:0]        sel_q, sel_d;
   logic [W-1:0]         dly_q, dly_d;
   logic                 over_q, over_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 busy_q, busy_d;
   logic [W-1:0]         count_q, count_d;

   logic [W-1:0]         delay_arr [NUM_REQ];
   logic                 req_found;
   logic [PW-1:0]        req_pick;
   logic [PW-1:0]        scan_idx;
   logic [PW-1:0]        sel_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign delay_arr[gi] = i_DELAY[gi*W +: W];
      end
   endgenerate

   // First set request at or above the pointer, wrapping around.
   always_comb begin
      req_found = 1'b0;
      req_pick  = '0;
      scan_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = PW'((int'(ptr_q) + i) % NUM_REQ);
         if (!req_found && i_REQ[scan_idx]) begin
            req_found = 1'b1;
            req_pick  = scan_idx;
         end
      end
   end

   assign sel_next = (sel_q == PW'(NUM_REQ - 1)) ? '0 : sel_q + PW'(1);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      dly_d   = dly_q;
      over_d  = over_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (req_found) begin
               sel_d   = req_pick;
               over_d  = delay_arr[req_pick] > THRESH;
               dly_d   = (delay_arr[req_pick] > THRESH) ? THRESH : delay_arr[req_pick];
               gnt_d   = NUM_REQ'(1) << req_pick;
               count_d = '0;
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            // A dropped request wins over a simultaneous terminal count.
            if (!i_REQ[sel_q]) begin
               state_d = S_IDLE;
               gnt_d   = '0;
               over_d  = 1'b0;
               count_d = '0;
               ptr_d   = sel_next;
            end else if (count_q == dly_q) begin
               state_d = S_DONE;
               gnt_d   = '0;
               over_d  = 1'b0;
               count_d = '0;
               done_d  = NUM_REQ'(1) << sel_q;
               ptr_d   = sel_next;
            end else begin
               count_d = count_q + W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         dly_q   <= '0;
         over_q  <= 1'b0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         dly_q   <= dly_d;
         over_q  <= over_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign o_GNT      = gnt_q;
   assign o_DONE     = done_q;
   assign o_BUSY     = busy_q;
   assign o_COUNT    = count_q;
   assign o_OVER_RUN = over_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler; expected done pulses are queued when a job is
// started and are matched against o_DONE as it pulses.
module tb_counter_scheduler;

   localparam int N  = 4;
   localparam int W  = 7;
   localparam int TH = 20;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] delay;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic           busy;
   logic [W-1:0]   count;
   logic           over;

   typedef struct {
      int    idx;
      int    cyc;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   counter_scheduler #(
      .NUM_REQ          (N),
      .COUNTER_MSB      (W-1),
      .COUNTER_THRESHOLD(TH)
   ) dut (
      .i_CLK      (clk),
      .i_RST_N    (rst_n),
      .i_REQ      (req),
      .i_DELAY    (delay),
      .o_GNT      (gnt),
      .o_DONE     (done),
      .o_BUSY     (busy),
      .o_COUNT    (count),
      .o_OVER_RUN (over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_delay(input int k, input int v);
      delay[k*W +: W] = W'(v);
   endtask

   task automatic push_done(input int k, input int at, input string tag);
      exp_t e;
      e.idx = k;
      e.cyc = at;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Advance one edge, then check o_DONE against the scoreboard.
   task automatic step();
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      if (done !== '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_done_idx"}, 32'(done), 32'(1) << e.idx);
            chk({e.tag, "_done_cyc"}, 32'(cyc), 32'(e.cyc));
         end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         chk({e.tag, "_done_missing"}, 32'(done), 32'(1) << e.idx);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      delay = '0;
      step();
      step();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_over", 32'(over), 0);
      rst_n = 1'b1;
      step();

      // Single job, delay 5
      set_delay(2, 5);
      req = 4'b0100;
      push_done(2, cyc + 1 + 6, "t1");
      step();
      chk("t1_gnt", 32'(gnt), 32'h4);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_count0", 32'(count), 0);
      chk("t1_over", 32'(over), 0);
      for (int c = 1; c <= 5; c++) begin
         step();
         chk($sformatf("t1_count%0d", c), 32'(count), 32'(c));
      end
      chk("t1_gnt_hold", 32'(gnt), 32'h4);
      step();
      chk("t1_gnt_at_done", 32'(gnt), 0);
      chk("t1_busy_at_done", 32'(busy), 1);
      req = '0;
      step();
      chk("t1_busy_low", 32'(busy), 0);

      // All four requesting with zero delay, from a fresh pointer
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      delay = '0;
      req   = 4'b1111;
      for (int j = 0; j < 5; j++) push_done(j % 4, cyc + 2 + 3*j, $sformatf("t2_%0d", j));
      for (int j = 0; j < 5; j++) begin
         step();
         chk($sformatf("t2_gnt%0d", j), 32'(gnt), 32'(1) << (j % 4));
         step();
         if (j == 4) req = '0;
         step();
         chk($sformatf("t2_idle_busy%0d", j), 32'(busy), 0);
      end

      // Clamped delay raises over-run; next normal job does not
      set_delay(0, 100);
      req = 4'b0001;
      push_done(0, cyc + 1 + 21, "t3");
      step();
      chk("t3_gnt", 32'(gnt), 32'h1);
      chk("t3_over", 32'(over), 1);
      for (int c = 1; c <= 20; c++) step();
      chk("t3_count_max", 32'(count), 20);
      chk("t3_over_hold", 32'(over), 1);
      step();
      chk("t3_over_at_done", 32'(over), 0);
      req = '0;
      step();
      set_delay(3, 3);
      req = 4'b1000;
      push_done(3, cyc + 1 + 4, "t3b");
      step();
      chk("t3b_gnt", 32'(gnt), 32'h8);
      chk("t3b_over", 32'(over), 0);
      for (int c = 1; c <= 4; c++) step();
      req = '0;
      step();

      // Abort at count 3, waiting requester 2 follows
      set_delay(1, 10);
      set_delay(2, 2);
      req = 4'b0110;
      step();
      chk("t4_gnt1", 32'(gnt), 32'h2);
      for (int c = 1; c <= 3; c++) step();
      chk("t4_count3", 32'(count), 3);
      req = 4'b0100;
      step();
      chk("t4_gnt_drop", 32'(gnt), 0);
      chk("t4_busy_drop", 32'(busy), 0);
      chk("t4_count_drop", 32'(count), 0);
      push_done(2, cyc + 1 + 3, "t4");
      step();
      chk("t4_gnt2", 32'(gnt), 32'h4);
      for (int c = 1; c <= 3; c++) step();
      req = '0;
      step();

      // Asynchronous reset mid-count
      set_delay(2, 9);
      req = 4'b0100;
      step();
      chk("t5_gnt", 32'(gnt), 32'h4);
      for (int c = 1; c <= 4; c++) step();
      chk("t5_count4", 32'(count), 4);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_gnt", 32'(gnt), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_count", 32'(count), 0);
      chk("t5_rst_over", 32'(over), 0);
      req = 4'b1101;
      set_delay(0, 1);
      step();
      rst_n = 1'b1;
      push_done(0, cyc + 1 + 2, "t5");
      step();
      chk("t5_gnt_after", 32'(gnt), 32'h1);
      step();
      step();
      req = '0;
      step();

      // Delay change after grant is ignored
      set_delay(1, 8);
      req = 4'b0010;
      push_done(1, cyc + 1 + 9, "t6");
      step();
      chk("t6_gnt", 32'(gnt), 32'h2);
      set_delay(1, 2);
      for (int c = 1; c <= 8; c++) step();
      chk("t6_count8", 32'(count), 8);
      step();
      req = '0;
      step();
      step();
      step();
      chk("sb_empty", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
